// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART register offsets, status bit positions and receiver states
package uart_pkg;

  localparam logic [7:0] TX_DATA_OFF = 8'h04;
  localparam logic [7:0] TX_STAT_OFF = 8'h08;
  localparam logic [7:0] RX_DATA_OFF = 8'h0C;
  localparam logic [7:0] RX_STAT_OFF = 8'h10;

  localparam int ST_NONEMPTY = 0;
  localparam int ST_OVERRUN  = 1;
  localparam int ST_FRAMEERR = 2;
  localparam int ST_FULL     = 3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous byte FIFO; a push on full is accepted when a pop frees the slot
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - 8N1 UART receiver with mid-bit sampling, receive FIFO and MMIO registers
`ifndef ADDR_W
`define ADDR_W 32
`endif

module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         ADDR_W       = `ADDR_W,
  parameter logic [7:0] RX_DATA_OFF  = uart_pkg::RX_DATA_OFF,
  parameter logic [7:0] RX_STAT_OFF  = uart_pkg::RX_STAT_OFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              mmio_req,
  input  logic              mmio_we,
  input  logic [ADDR_W-1:0] mmio_addr,
  input  logic [31:0]       mmio_wdata,
  output logic [31:0]       mmio_rdata,
  output logic              mmio_ready,
  output logic              rx_irq
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_s;
  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             tick;
  logic             push;
  logic             ferr_set;
  logic             pop;
  logic             pop_pend;
  logic [7:0]       fifo_rdata;
  logic             full;
  logic             empty;
  logic             overrun;
  logic             frame_err;
  logic             take;
  logic             is_data;
  logic             is_stat;
  logic             clr_ovr;
  logic             clr_ferr;
  logic             unused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick     = (cnt == '0);
  assign push     = (state == RX_STOP) && tick && rx_s;
  assign ferr_set = (state == RX_STOP) && tick && !rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_BIT;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (!tick) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rx_s) begin
            cnt   <= FULL_BIT;
            idx   <= '0;
            state <= RX_DATA;
          end else begin
            state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (!tick) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shreg[idx] <= rx_s;
            cnt        <= FULL_BIT;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (!tick) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_s) begin
            state <= RX_IDLE;
          end else begin
            state <= RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          // a held-low break is reported once, not once per frame time
          if (rx_s) begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (shreg),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  assign take     = mmio_req && !mmio_ready;
  assign is_data  = (mmio_addr[4:0] == RX_DATA_OFF[4:0]);
  assign is_stat  = (mmio_addr[4:0] == RX_STAT_OFF[4:0]);
  assign clr_ovr  = take && mmio_we && is_stat && mmio_wdata[1];
  assign clr_ferr = take && mmio_we && is_stat && mmio_wdata[2];
  // the head byte was captured at request time and leaves the FIFO in the ready cycle
  assign pop      = pop_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mmio_ready <= 1'b0;
      mmio_rdata <= '0;
      pop_pend   <= 1'b0;
    end else begin
      mmio_ready <= take;
      pop_pend   <= take && !mmio_we && is_data && !empty;
      mmio_rdata <= '0;
      if (take && !mmio_we) begin
        if (is_data && !empty) begin
          mmio_rdata <= {23'b0, 1'b1, fifo_rdata};
        end else if (is_stat) begin
          mmio_rdata[ST_NONEMPTY] <= !empty;
          mmio_rdata[ST_OVERRUN]  <= overrun;
          mmio_rdata[ST_FRAMEERR] <= frame_err;
          mmio_rdata[ST_FULL]     <= full;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (push && full && !pop) || (overrun && !clr_ovr);
      frame_err <= ferr_set || (frame_err && !clr_ferr);
    end
  end

  assign rx_irq = !empty;
  assign unused = ^{mmio_addr[ADDR_W-1:5], mmio_wdata[31:3], mmio_wdata[0]};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - scoreboard bench for uart_rx_mmio with directed serial frames and MMIO reads
module tb_uart_rx_mmio;

  localparam int         CPB  = 16;
  localparam logic [7:0] DATA = 8'h0C;
  localparam logic [7:0] STAT = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        mmio_req = 1'b0;
  logic        mmio_we = 1'b0;
  logic [31:0] mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;
  logic        rx_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .ADDR_W       (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .mmio_req   (mmio_req),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .mmio_ready (mmio_ready),
    .rx_irq     (rx_irq)
  );

  always #5 clk = ~clk;

  // monitor: every completion pulse consumes one scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mmio_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready rdata=%h", mmio_rdata);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) begin
          checks++;
          if (mmio_rdata !== e.val) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", e.name, mmio_rdata, e.val);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic access(input bit we, input logic [7:0] off, input logic [31:0] wd,
                        input logic [31:0] exp, input string name);
    exp_t e;
    bit   got;
    e.chk = !we;
    e.val = exp;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    mmio_req   = 1'b1;
    mmio_we    = we;
    mmio_addr  = {24'b0, off};
    mmio_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mmio_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=no_ready expected=ready", name);
      e = exp_q.pop_back();
    end
    @(posedge clk);
    #1;
    mmio_req = 1'b0;
    mmio_we  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    access(1'b0, off, 32'h0, exp, name);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd);
    access(1'b1, off, wd, 32'h0, "write");
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    @(posedge clk);
    #1 uart_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 uart_rx = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 uart_rx = stop;
    repeat (CPB) @(posedge clk);
    #1 uart_rx = stop;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] t2 [5];
    t2[0] = 8'hA5; t2[1] = 8'h5A; t2[2] = 8'h3C; t2[3] = 8'hC3; t2[4] = 8'h99;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'b0, mmio_ready}, 32'h0);
    check("reset_rdata", mmio_rdata, 32'h0);
    check("reset_irq", {31'b0, rx_irq}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 1: sixteen frames, each read back in order
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 17);
      send_frame(b, 1'b1);
      check("t1_irq", {31'b0, rx_irq}, 32'h1);
      rd(DATA, 32'h100 | {24'b0, b}, "t1_data");
    end
    rd(STAT, 32'h0, "t1_stat");
    rd(8'h14, 32'h0, "other_off_read");
    wr(DATA, 32'hFF);
    rd(STAT, 32'h0, "data_write_ignored");

    // 2: overrun
    for (int i = 0; i < 5; i++) send_frame(t2[i], 1'b1);
    rd(STAT, 32'hB, "t2_stat_full_ovr");
    for (int i = 0; i < 4; i++) rd(DATA, 32'h100 | {24'b0, t2[i]}, "t2_data");
    rd(DATA, 32'h0, "t2_empty_read");
    wr(STAT, 32'h2);
    rd(STAT, 32'h0, "t2_ovr_cleared");

    // 3: framing error then break
    send_frame(8'h55, 1'b0);
    repeat (100) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (20) @(posedge clk);
    rd(STAT, 32'h4, "t3_ferr_empty");
    send_frame(8'h42, 1'b1);
    rd(STAT, 32'h5, "t3_ferr_nonempty");
    rd(DATA, 32'h142, "t3_data");
    wr(STAT, 32'h4);
    rd(STAT, 32'h0, "t3_ferr_cleared");

    // 4: short glitch
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (30) @(posedge clk);
    rd(STAT, 32'h0, "t4_stat");
    rd(DATA, 32'h0, "t4_data");
    check("t4_irq", {31'b0, rx_irq}, 32'h0);

    // 5: pop coincides with push on a full FIFO
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    rd(STAT, 32'h9, "t5_stat_full");
    fork
      send_frame(8'h05, 1'b1);
      begin
        @(posedge clk);
        repeat (152) @(posedge clk);
        rd(DATA, 32'h101, "t5_pop_with_push");
      end
    join
    rd(STAT, 32'h9, "t5_stat_no_ovr");
    for (int i = 2; i <= 5; i++) rd(DATA, 32'h100 | i, "t5_data");
    rd(STAT, 32'h0, "t5_stat_empty");

    // 6: reset in the middle of a frame
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mmio_req  = 1'b1;
    mmio_addr = {24'b0, STAT};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_ready_in_reset", {31'b0, mmio_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    mmio_req = 1'b0;
    uart_rx  = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    rd(STAT, 32'h0, "t6_no_partial");
    send_frame(8'h7E, 1'b1);
    rd(DATA, 32'h17E, "t6_data");
    rd(STAT, 32'h0, "t6_stat");

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
